// File: rtl/regwrite_trace_fifo_pkg.sv
// Shared trace types: entry record layout, field widths and default FIFO geometry.
// Consumed by the trace FIFO top and its storage.
package regwrite_trace_fifo_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_CYC_W = 16;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;

  // Default-width entry; the top re-declares the same layout with its own CYC_W.
  typedef struct packed {
    logic [REG_W-1:0]     wreg;
    logic [DATA_W-1:0]    data;
    logic [DEF_CYC_W-1:0] cycle;
  } trace_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/regwrite_trace_fifo_trace_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
// Write lands on the rising clock edge; the read is combinational, with no backpressure.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 53
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/regwrite_trace_fifo.sv
// Captures processor regfile writes on divided-clock rising edges, stamped with a cycle count.
// Zero-cycle read latency; a push that arrives while the FIFO is full and not popping is dropped and counted.
module regwrite_trace_fifo
  import regwrite_trace_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   regfile_clock,
  input  logic                   ctrl_writeEnable,
  input  logic [REG_W-1:0]       ctrl_writeReg,
  input  logic [DATA_W-1:0]      data_writeReg,
  input  logic                   clr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [REG_W-1:0]       rd_reg,
  output logic [DATA_W-1:0]      rd_data,
  output logic [CYC_W-1:0]       rd_cycle,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
    logic [CYC_W-1:0]  cycle;
  } entry_t;

  logic              rfclk_d;
  logic              we_d;
  logic [REG_W-1:0]  wreg_d;
  logic [DATA_W-1:0] wdata_d;
  logic              armed;

  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CYC_W-1:0]  cyc;

  logic              rf_rise;
  logic              push;
  logic              pop;
  logic              full;
  logic              accept;
  logic              drop;
  entry_t            wr_ent;
  entry_t            rd_ent;

  // armed masks the first cycle after reset so a high regfile_clock is not mistaken for an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rfclk_d <= 1'b0;
      we_d    <= 1'b0;
      wreg_d  <= '0;
      wdata_d <= '0;
      armed   <= 1'b0;
    end else begin
      rfclk_d <= regfile_clock;
      we_d    <= ctrl_writeEnable;
      wreg_d  <= ctrl_writeReg;
      wdata_d <= data_writeReg;
      armed   <= 1'b1;
    end
  end

  always_comb begin
    rf_rise = armed & regfile_clock & ~rfclk_d;
    push    = rf_rise & we_d & (wreg_d != '0) & ~clr;
    pop     = rd_valid & rd_ready & ~clr;
    full    = (level == LW'(DEPTH));
    accept  = push & (~full | pop);
    drop    = push & full & ~pop;
    wr_ent  = '{wreg: wreg_d, data: wdata_d, cycle: cyc};
  end

  assign rd_valid = (level != '0);
  assign rd_reg   = rd_ent.wreg;
  assign rd_data  = rd_ent.data;
  assign rd_cycle = rd_ent.cycle;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      cyc      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      cyc      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (rf_rise) cyc  <= cyc + CYC_W'(1);
      if (accept)  tail <= tail + AW'(1);
      if (pop)     head <= head + AW'(1);
      case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_trace_ram (
    .clock (clock),
    .we    (accept),
    .waddr (tail),
    .wdata (wr_ent),
    .raddr (head),
    .rdata (rd_ent)
  );

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// Directed bench for regwrite_trace_fifo: a queue model checked every cycle plus literal pins.
// CYC_W is narrowed to 10 so the timestamp wrap is reachable within a short run.
module tb_regwrite_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CYC_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              regfile_clock = 1'b0;
  logic              ctrl_writeEnable = 1'b0;
  logic [4:0]        ctrl_writeReg = '0;
  logic [31:0]       data_writeReg = '0;
  logic              clr = 1'b0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [4:0]        rd_reg;
  logic [31:0]       rd_data;
  logic [CYC_W-1:0]  rd_cycle;
  logic [4:0]        level;
  logic              overflow;
  logic [7:0]        drop_cnt;

  regwrite_trace_fifo #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .regfile_clock    (regfile_clock),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .clr              (clr),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_reg           (rd_reg),
    .rd_data          (rd_data),
    .rd_cycle         (rd_cycle),
    .level            (level),
    .overflow         (overflow),
    .drop_cnt         (drop_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]       r;
    logic [31:0]      d;
    logic [CYC_W-1:0] c;
  } ent_t;

  ent_t        m_q[$];
  int          m_cyc;
  bit          m_ovf;
  int          m_drop;
  bit          p_rf, p_we, skip, rise;
  logic [4:0]  p_reg;
  logic [31:0] p_dat;

  always @(posedge clock) begin
    if (!reset) begin
      m_q.delete();
      m_cyc = 0; m_ovf = 0; m_drop = 0;
      p_rf = 0; p_we = 0; p_reg = '0; p_dat = '0; skip = 1;
    end else begin
      rise = !skip && regfile_clock && !p_rf;
      if (clr) begin
        m_q.delete();
        m_cyc = 0; m_ovf = 0; m_drop = 0;
      end else begin
        if (m_q.size() > 0 && rd_ready) void'(m_q.pop_front());
        if (rise && p_we && p_reg != 0) begin
          if (m_q.size() < DEPTH) m_q.push_back('{r: p_reg, d: p_dat, c: m_cyc[CYC_W-1:0]});
          else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
        if (rise) m_cyc = (m_cyc + 1) % (1 << CYC_W);
      end
      skip = 0;
      p_rf = regfile_clock; p_we = ctrl_writeEnable; p_reg = ctrl_writeReg; p_dat = data_writeReg;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("rd_valid", rd_valid, m_q.size() != 0);
      chk("level", level, m_q.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (m_q.size() != 0) begin
        chk("head_reg", rd_reg, m_q[0].r);
        chk("head_data", rd_data, m_q[0].d);
        chk("head_cycle", rd_cycle, m_q[0].c);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rf_edge(input logic [4:0] r, input logic [31:0] d, input bit we, input bit pop_on_edge);
    ctrl_writeEnable = we;
    ctrl_writeReg    = r;
    data_writeReg    = d;
    regfile_clock    = 1'b0;
    tick();
    regfile_clock = 1'b1;
    rd_ready      = pop_on_edge;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Release reset with regfile_clock already high: must not count as an edge.
    regfile_clock = 1'b1; ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'h1234;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("no_edge_after_rst", level, 0);

    // Single write; rd_cycle 0 also proves the release cycle did not advance the counter.
    rf_edge(5'd3, 32'h0000_00AA, 1'b1, 1'b0);
    chk("single_valid", rd_valid, 1);
    chk("single_reg", rd_reg, 3);
    chk("single_data", rd_data, 32'h0000_00AA);
    chk("single_cycle", rd_cycle, 0);
    rd_ready = 1'b1; tick(); tick(); rd_ready = 1'b0;
    chk("pop_then_empty", level, 0);

    // r0 writes are filtered but still advance the timestamp.
    do_clr();
    rf_edge(5'd0, 32'h55, 1'b1, 1'b0);
    chk("r0_level", level, 0);
    rf_edge(5'd7, 32'h11, 1'b1, 1'b0);
    chk("r0_cnt_adv", rd_cycle, 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // Overflow: 18 edges into a 16-deep FIFO.
    do_clr();
    for (int i = 0; i < 18; i++) rf_edge(5'((i % 31) + 1), 32'h100 + i, 1'b1, 1'b0);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_head_data", rd_data, 32'h100);
    chk("ovf_head_cycle", rd_cycle, 0);

    // Full with simultaneous push/pop: accepted, no overflow, new entry at the tail.
    do_clr();
    for (int i = 0; i < 16; i++) rf_edge(5'((i % 31) + 1), 32'h200 + i, 1'b1, 1'b0);
    rf_edge(5'd9, 32'hBEEF, 1'b1, 1'b1);
    chk("fullpp_level", level, 16);
    chk("fullpp_ovf", overflow, 0);
    rd_ready = 1'b1; repeat (15) tick(); rd_ready = 1'b0;
    chk("fullpp_tail_data", rd_data, 32'hBEEF);
    chk("fullpp_tail_reg", rd_reg, 9);
    chk("fullpp_tail_cycle", rd_cycle, 16);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // drop_cnt = 7 then clr; then saturation at 255.
    do_clr();
    for (int i = 0; i < 23; i++) rf_edge(5'd2, i, 1'b1, 1'b0);
    chk("drop7", drop_cnt, 7);
    do_clr();
    chk("clr_drop", drop_cnt, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_level", level, 0);
    for (int i = 0; i < 276; i++) rf_edge(5'd4, i, 1'b1, 1'b0);
    chk("drop_sat", drop_cnt, 255);

    // Reset pulse with level 5.
    do_clr();
    for (int i = 0; i < 5; i++) rf_edge(5'd6, 32'h300 + i, 1'b1, 1'b0);
    chk("pre_rst_level", level, 5);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", rd_valid, 0);
    chk("async_rst_level", level, 0);
    tick();
    reset = 1'b1;
    tick();

    // Ordering across 40 push/pop pairs at level 3 (pointers wrap twice).
    for (int i = 0; i < 3; i++) rf_edge(5'd8, 32'hC000 + i, 1'b1, 1'b0);
    for (int i = 3; i < 43; i++) rf_edge(5'((i % 31) + 1), 32'hC000 + i, 1'b1, 1'b1);
    chk("order_level", level, 3);
    chk("order_head", rd_data, 32'hC000 + 40);
    rd_ready = 1'b1; repeat (3) tick(); rd_ready = 1'b0;

    // Timestamp wrap: 2^CYC_W + 1 edges, last entry stamped 0.
    do_clr();
    for (int i = 0; i <= (1 << CYC_W); i++) rf_edge(5'd1, i, 1'b1, 1'b1);
    chk("wrap_level", level, 1);
    chk("wrap_cycle", rd_cycle, 0);
    chk("wrap_data", rd_data, 1 << CYC_W);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regwrite_trace_fifo.md
REGWRITE_TRACE_FIFO -- requirements
Module: regwrite_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter CYC_W, default 16, meaning width of the processor-cycle timestamp.
REQ-003 SHALL have port clock, input, 1, meaning the single system clock (the undivided clock); all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port regfile_clock, input, 1, meaning the divided regfile clock, sampled as data and never used as a clock.
REQ-006 SHALL have ports ctrl_writeEnable (1), ctrl_writeReg (5) and data_writeReg (32), all inputs, meaning the processor's regfile write request.
REQ-007 SHALL have port clr, input, 1, meaning synchronous trace clear.
REQ-008 SHALL have ports rd_valid (output, 1) and rd_ready (input, 1), meaning the read handshake.
REQ-009 SHALL have ports rd_reg (output, 5), rd_data (output, 32) and rd_cycle (output, CYC_W), meaning the head entry.
REQ-010 SHALL have port level, output, clog2(DEPTH)+1, meaning occupancy.
REQ-011 SHALL have port overflow, output, 1, meaning a sticky flag set when an entry was dropped.
REQ-012 SHALL have port drop_cnt, output, 8, meaning the number of dropped entries, saturating.

Function
REQ-013 SHALL register regfile_clock, ctrl_writeEnable, ctrl_writeReg and data_writeReg every clock cycle into a one-stage delay.
REQ-014 SHALL detect an edge when regfile_clock is 1 and its delayed copy is 0.
REQ-015 SHALL, on each edge, increment the cycle counter modulo 2^CYC_W; counter value 2^CYC_W-1 SHALL wrap to 0.
REQ-016 SHALL raise a push request on an edge when delayed ctrl_writeEnable=1 and delayed ctrl_writeReg!=0.
REQ-017 SHALL build a pushed entry from the delayed reg and delayed data (the values present before the edge) plus the cycle counter value before the increment.
REQ-018 SHALL drive rd_valid = (level!=0), with rd_reg, rd_data and rd_cycle showing the head entry combinationally from storage.
REQ-019 SHALL pop when rd_valid and rd_ready are both high; rd_ready while empty SHALL have no effect.
REQ-020 SHALL, on push with level<DEPTH, write at the tail and increment level.
REQ-021 SHALL, on push with level=DEPTH and no pop in the same cycle, drop the entry, set overflow, and increment drop_cnt up to 255.
REQ-022 SHALL, on simultaneous push and pop when full, accept the push and leave level unchanged.
REQ-023 SHALL, on simultaneous push and pop when level is 1..DEPTH-1, leave level unchanged and preserve ordering.
REQ-024 SHALL use head and tail pointers that wrap from DEPTH-1 to 0.
REQ-025 SHALL, when clr=1, empty the FIFO, clear overflow, drop_cnt and the cycle counter, and ignore any push or pop in that cycle; the delay stage keeps sampling.
REQ-026 SHALL have zero-cycle read latency: an entry pushed in cycle N SHALL be visible with rd_valid=1 in cycle N+1.

Reset
REQ-027 SHALL, while reset=0, asynchronously force pointers, level, cycle counter, overflow, drop_cnt and the delay stage to 0, so that rd_valid=0.
REQ-028 SHALL leave storage contents unreset; outputs derived from storage are don't-care while rd_valid=0.
REQ-029 SHALL treat reset asserted mid-operation as discarding all entries, with no edge detected in the first cycle after release.

Structure
REQ-030 SHALL place the entry record typedef (reg, data, cycle fields) and the DEPTH and CYC_W defaults in a shared trace package.
REQ-031 SHALL implement storage as one sub-module, trace_ram: DEPTH-by-entry-width, one synchronous write port and one asynchronous read port.

Verification
REQ-032 Single write: a regfile_clock edge with reg 3 and data 0x0000_00AA -> rd_valid next cycle, rd_reg=3, rd_data=0xAA, rd_cycle=0.
REQ-033 r0 filter: a write to reg 0 on an edge -> level stays 0, and the cycle counter still advances to 1.
REQ-034 Overflow: 18 write edges with rd_ready=0 and DEPTH=16 -> level=16, overflow=1, drop_cnt=2, and the head holds the first entry.
REQ-035 Full push/pop: with level=16, an edge coinciding with rd_ready=1 -> level=16, overflow stays 0, and the new entry lands at the tail.
REQ-036 Wrap: 2^16+1 edges -> rd_cycle of the last entry is 0, and the pointers wrap with FIFO order preserved across 40 push/pop pairs.
REQ-037 Reset/clr: reset pulsed low with level=5 -> rd_valid=0 immediately; clr with drop_cnt=7 -> drop_cnt=0 and overflow=0 next cycle.
